// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// the LSU flag bytes also used by the transmit side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // 50 MHz system clock at 9600 baud
  localparam int unsigned CLKS_PER_BIT_DEF = 5208;

  localparam logic [7:0] LOAD_FLAG  = 8'h01;
  localparam logic [7:0] STORE_FLAG = 8'h02;

  function automatic logic rx_state_busy(input rx_state_e s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops preset
// to 1 so an idle-high line reads idle straight out of reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, LSB first,
// one-cycle strobes for a good byte or a framing error.
//
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | timing to start-bit middle; high there means glitch
//   DATA      | sampling 8 data bits one bit period apart
//   STOP      | sampling stop bit; high delivers byte, low flags error
//   WAIT_IDLE | line stuck low after a framing error; wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_do,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int          CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rx_s;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q,  data_d;
  logic             do_q,    do_d;
  logic             ferr_q,  ferr_d;
  logic             busy_q,  busy_d;

  sync_2ff u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= 8'h00;
      do_q    <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      do_q    <= do_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    do_d    = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        // Leaving at mid-stop gives half a bit of slack for a back-to-back start
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            do_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = rx_state_busy(state_d);
  end

  assign rx_do     = do_q;
  assign rx_data   = data_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (16 and 4 clk per bit) driven by
// a serial frame generator; a negedge monitor pops expected bytes on rx_do.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx16 = 1'b1;
  logic       rx4 = 1'b1;
  logic       do16, ferr16, busy16;
  logic       do4, ferr4, busy4;
  logic [7:0] data16, data4;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(reset), .rx(rx16), .rx_do(do16),
    .rx_data(data16), .frame_err(ferr16), .rx_busy(busy16)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .rx(rx4), .rx_do(do4),
    .rx_data(data4), .frame_err(ferr4), .rx_busy(busy4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    longint     t0;
  } exp_t;

  exp_t       q16[$];
  exp_t       q4[$];
  logic [7:0] log16[$];
  longint     tlog16[$];
  int         checks = 0;
  int         failures = 0;
  int         ferr_exp[2] = '{0, 0};
  int         ferr_seen[2] = '{0, 0};
  int         do_cnt[2] = '{0, 0};
  int         viol[2] = '{0, 0};
  logic [7:0] model[2] = '{8'h00, 8'h00};
  logic       prev_strobe[2] = '{1'b0, 1'b0};

  function automatic int per(input int s);
    return (s == 0) ? 16 : 4;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: a good frame appears as its byte ~9.5 bit times + 3 clk after
  // the start edge; a low stop bit appears only as one frame_err pulse.
  task automatic mon(input int s, input logic d, input logic f, input logic [7:0] dat);
    exp_t   e;
    longint lat;
    longint want;
    if (!reset) begin
      model[s] = 8'h00;
      prev_strobe[s] = 1'b0;
      return;
    end
    if (d && f) viol[s]++;
    if ((d || f) && prev_strobe[s]) viol[s]++;
    prev_strobe[s] = d || f;
    if (f) ferr_seen[s]++;
    if (d) begin
      do_cnt[s]++;
      if ((s == 0 && q16.size() == 0) || (s == 1 && q4.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rx_do dut%0d: actual data=%0h required no strobe", s, dat);
      end else begin
        if (s == 0) e = q16.pop_front();
        else e = q4.pop_front();
        check($sformatf("rx_data dut%0d", s), longint'(dat), longint'(e.data));
        lat  = ($time - e.t0 - 5) / 10;
        want = longint'((19 * per(s)) / 2 + 3);
        checks++;
        if (lat < want - 1 || lat > want + 1) begin
          failures++;
          $display("FAIL latency dut%0d: actual=%0d required=%0d+-1", s, lat, want);
        end
        model[s] = e.data;
        if (s == 0) begin
          log16.push_back(dat);
          tlog16.push_back($time);
        end
      end
    end
    if (dat !== model[s]) viol[s]++;
  endtask

  always @(negedge clk) begin
    mon(0, do16, ferr16, data16);
    mon(1, do4, ferr4, data4);
  end

  task automatic set_rx(input int s, input logic v);
    if (s == 0) rx16 = v;
    else rx4 = v;
  endtask

  task automatic send_frame(input int s, input logic [7:0] b, input logic stop_bit,
                            input logic expect_it);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    e.data = b;
    e.t0   = $time - 1;
    if (expect_it) begin
      if (!stop_bit) ferr_exp[s]++;
      else if (s == 0) q16.push_back(e);
      else q4.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      set_rx(s, bits[i]);
      repeat (per(s) - 1) @(posedge clk);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     d0;
    int     f0;
    int     gap;
    logic [7:0] b;
    logic   stp;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    settle(1);
    check("reset rx_do16", do16, 0);
    check("reset frame_err16", ferr16, 0);
    check("reset rx_busy16", busy16, 0);
    check("reset rx_data16", data16, 8'h00);
    check("reset rx_do4", do4, 0);
    check("reset rx_busy4", busy4, 0);
    check("reset rx_data4", data4, 8'h00);

    // single byte
    fork
      send_frame(0, 8'hA5, 1'b1, 1'b1);
      begin
        settle(40);
        check("busy mid-frame", busy16, 1);
      end
    join
    settle(10);
    check("single queue drained", q16.size(), 0);
    check("single rx_data", data16, 8'hA5);
    check("single busy after", busy16, 0);
    check("single no frame_err", ferr_seen[0], 0);

    // back-to-back word
    log16.delete();
    tlog16.delete();
    send_frame(0, 8'hBE, 1'b1, 1'b1);
    send_frame(0, 8'hEF, 1'b1, 1'b1);
    settle(10);
    check("b2b pulses", log16.size(), 2);
    if (log16.size() == 2) begin
      check("b2b word", {log16[0], log16[1]}, 16'hBEEF);
      check("b2b spacing", (tlog16[1] - tlog16[0]) / 10, 160);
    end

    // glitch
    d0 = do_cnt[0];
    @(posedge clk);
    #1 rx16 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx16 = 1'b1;
    settle(30);
    check("glitch no rx_do", do_cnt[0], d0);
    check("glitch no frame_err", ferr_seen[0], 0);
    check("glitch back idle", busy16, 0);
    send_frame(0, 8'h3C, 1'b1, 1'b1);
    settle(10);
    check("after glitch rx_data", data16, 8'h3C);

    // framing error with line held low
    d0 = do_cnt[0];
    send_frame(0, 8'h55, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1 rx16 = 1'b1;
    settle(20);
    check("ferr count", ferr_seen[0], 1);
    check("ferr no rx_do", do_cnt[0], d0);
    check("ferr keeps rx_data", data16, 8'h3C);
    send_frame(0, 8'hC3, 1'b1, 1'b1);
    settle(10);
    check("after ferr rx_data", data16, 8'hC3);

    // reset during data bit 4 of a 0xFF frame
    d0 = do_cnt[0];
    f0 = ferr_seen[0];
    fork
      send_frame(0, 8'hFF, 1'b1, 1'b0);
      begin
        repeat (88) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("midreset rx_data", data16, 8'h00);
        check("midreset rx_busy", busy16, 0);
        check("midreset rx_do", do16, 0);
        check("midreset frame_err", ferr16, 0);
        reset = 1'b1;
      end
    join
    settle(40);
    check("midreset no rx_do", do_cnt[0], d0);
    check("midreset no frame_err", ferr_seen[0], f0);
    send_frame(0, 8'h81, 1'b1, 1'b1);
    settle(10);
    check("after reset rx_data", data16, 8'h81);

    // boundaries on both bit rates
    for (int s = 0; s < 2; s++) begin
      send_frame(s, 8'h00, 1'b1, 1'b1);
      settle(5);
      check($sformatf("bound 00 dut%0d", s), (s == 0) ? data16 : data4, 8'h00);
      send_frame(s, 8'hFF, 1'b1, 1'b1);
      settle(5);
      check($sformatf("bound FF dut%0d", s), (s == 0) ? data16 : data4, 8'hFF);
    end
    send_frame(1, 8'hA5, 1'b1, 1'b1);
    send_frame(1, 8'hBE, 1'b1, 1'b1);
    send_frame(1, 8'hEF, 1'b1, 1'b1);
    settle(5);
    check("dut4 b2b last", data4, 8'hEF);
    send_frame(1, 8'h55, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1 rx4 = 1'b1;
    settle(10);
    check("dut4 ferr keeps rx_data", data4, 8'hEF);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      for (int s = 0; s < 2; s++) begin
        b   = 8'($urandom);
        stp = ($urandom_range(0, 7) != 0);
        send_frame(s, b, stp, 1'b1);
        if (!stp) begin
          repeat (per(s)) @(posedge clk);
          #1 set_rx(s, 1'b1);
          repeat (2 * per(s)) @(posedge clk);
        end else begin
          gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
          repeat (gap) @(posedge clk);
        end
      end
    end

    settle(60);
    check("final q16 drained", q16.size(), 0);
    check("final q4 drained", q4.size(), 0);
    check("final ferr dut16", ferr_seen[0], ferr_exp[0]);
    check("final ferr dut4", ferr_seen[1], ferr_exp[1]);
    check("strobe/data rules dut16", viol[0], 0);
    check("strobe/data rules dut4", viol[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
